// File: rtl/slave_port_if.sv
// Serial bus plus local memory-side signals of the slave port.
// The slave modport is the DUT view; the master modport drives it.
interface slave_port_if;
    logic        B_UTIL;
    logic        B_RW;
    logic        B_BUS_IN;
    logic        B_BUS_OUT;
    logic        B_BUS_OE;
    logic        B_ACK;
    logic [11:0] S_ADDR;
    logic [7:0]  S_DOUT;
    logic [7:0]  S_DIN;
    logic        S_WEN;
    logic        S_REN;
    logic        S_READY;
    logic        S_BSY;

    modport slave (
        input  B_UTIL, B_RW, B_BUS_IN, S_DIN, S_READY,
        output B_BUS_OUT, B_BUS_OE, B_ACK,
        output S_ADDR, S_DOUT, S_WEN, S_REN, S_BSY
    );

    modport master (
        output B_UTIL, B_RW, B_BUS_IN, S_DIN, S_READY,
        input  B_BUS_OUT, B_BUS_OE, B_ACK,
        input  S_ADDR, S_DOUT, S_WEN, S_REN, S_BSY
    );
endinterface

// File: rtl/slave_port.sv
// Serial bus slave: shifts in address/write data, decodes its ID,
// runs one local read or write beat and shifts read data back out.
module slave_port #(
    parameter logic [3:0] SLAVE_ID = 4'h1
) (
    input logic        CLK,
    input logic        RSTN,
    slave_port_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        CHECK,
        ACK_A,
        WDATA,
        WMEM,
        RMEM,
        ACK_D,
        RDATA,
        WAIT_END
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        rw_q, rw_d;
    logic        abort;

    always_ff @(posedge CLK) begin
        if (RSTN) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'd0;
            data_q  <= 8'd0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rw_q    <= rw_d;
        end
    end

    // Master dropping B_UTIL mid-transaction returns us to IDLE untouched.
    assign abort = !bus.B_UTIL && (state_q != IDLE) && (state_q != WAIT_END);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rw_d    = rw_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.B_UTIL) begin
                        addr_d[0] = bus.B_BUS_IN;
                        rw_d      = bus.B_RW;
                        cnt_d     = 4'd1;
                        state_d   = ADDR;
                    end
                end
                ADDR: begin
                    addr_d[cnt_q] = bus.B_BUS_IN;
                    cnt_d         = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) state_d = CHECK;
                end
                CHECK: begin
                    if (addr_q[15:12] == SLAVE_ID) state_d = ACK_A;
                    else state_d = WAIT_END;
                end
                ACK_A: begin
                    cnt_d   = 4'd0;
                    state_d = rw_q ? WDATA : RMEM;
                end
                WDATA: begin
                    data_d[cnt_q[2:0]] = bus.B_BUS_IN;
                    cnt_d              = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) state_d = WMEM;
                end
                WMEM: begin
                    if (bus.S_READY) state_d = ACK_D;
                end
                RMEM: begin
                    if (bus.S_READY) begin
                        data_d  = bus.S_DIN;
                        state_d = ACK_D;
                    end
                end
                ACK_D: begin
                    cnt_d   = 4'd0;
                    state_d = rw_q ? WAIT_END : RDATA;
                end
                RDATA: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) state_d = WAIT_END;
                end
                WAIT_END: begin
                    if (!bus.B_UTIL) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.B_ACK     = (state_q == ACK_A) || (state_q == ACK_D);
    assign bus.B_BUS_OE  = (state_q == RDATA);
    assign bus.B_BUS_OUT = bus.B_BUS_OE & data_q[cnt_q[2:0]];
    assign bus.S_WEN     = (state_q == WMEM);
    assign bus.S_REN     = (state_q == RMEM);
    assign bus.S_BSY     = (state_q != IDLE);
    assign bus.S_ADDR    = addr_q[11:0];
    assign bus.S_DOUT    = data_q;

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port: transaction table plus abort,
// reset-during-read and back-to-back sequences.
module tb_slave_port;

    logic CLK = 1'b0;
    logic RSTN;

    slave_port_if bus();

    slave_port #(.SLAVE_ID(4'h1)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    int ack_n = 0;
    int wen_n = 0;
    int ren_n = 0;
    int oe_n = 0;
    int viol_n = 0;
    logic prev_ack = 1'b0;
    logic [11:0] w_addr = '0;
    logic [7:0] w_dout = '0;
    logic [7:0] rbits = '0;

    // Observe every cycle mid-period, away from the active edge.
    always @(negedge CLK) begin
        if (bus.B_ACK) ack_n++;
        if (bus.B_ACK && prev_ack) viol_n++;
        prev_ack = bus.B_ACK;
        if (bus.S_WEN && bus.S_REN) viol_n++;
        if (!bus.B_BUS_OE && bus.B_BUS_OUT) viol_n++;
        if (bus.S_WEN) begin
            wen_n++;
            w_addr = bus.S_ADDR;
            w_dout = bus.S_DOUT;
        end
        if (bus.S_REN) ren_n++;
        if (bus.B_BUS_OE) begin
            oe_n++;
            rbits = {bus.B_BUS_OUT, rbits[7:1]};
        end
    end

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  sdin;
        int          rdelay;
        logic        early;
        int          rst_bit;
        logic        hit;
        int          acks;
        int          wens;
        int          rens;
        int          oes;
        logic [7:0]  rdata;
    } vec_t;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, bus.B_ACK, 0);
        chk({tag, "_bus_out"}, bus.B_BUS_OUT, 0);
        chk({tag, "_bus_oe"}, bus.B_BUS_OE, 0);
        chk({tag, "_wen"}, bus.S_WEN, 0);
        chk({tag, "_ren"}, bus.S_REN, 0);
        chk({tag, "_bsy"}, bus.S_BSY, 0);
        chk({tag, "_s_addr"}, bus.S_ADDR, 0);
        chk({tag, "_s_dout"}, bus.S_DOUT, 0);
    endtask

    task automatic xact(input vec_t v);
        int a0, w0, r0, o0, sc, ob;
        logic rst_hit;
        a0 = ack_n;
        w0 = wen_n;
        r0 = ren_n;
        o0 = oe_n;
        sc = 0;
        ob = 0;
        rst_hit = 1'b0;
        bus.S_READY  = v.early;
        bus.S_DIN    = v.sdin;
        bus.B_RW     = v.rw;
        bus.B_UTIL   = 1'b1;
        bus.B_BUS_IN = v.addr[0];
        for (int i = 1; i < 16; i++) begin
            cyc();
            bus.B_BUS_IN = v.addr[i];
        end
        cyc();
        chk("ack_in_check", bus.B_ACK, 0);
        cyc();
        chk("addr_ack", bus.B_ACK, v.hit);
        if (v.rw) begin
            cyc();
            bus.B_BUS_IN = v.wdata[0];
            for (int i = 1; i < 8; i++) begin
                cyc();
                bus.B_BUS_IN = v.wdata[i];
            end
        end
        for (int k = 0; k < 30; k++) begin
            if (bus.S_WEN || bus.S_REN) begin
                bus.S_READY = (sc == v.rdelay);
                sc++;
            end else begin
                bus.S_READY = v.early;
            end
            if (bus.B_BUS_OE && ob == v.rst_bit) begin
                rst_hit = 1'b1;
                break;
            end
            if (bus.B_BUS_OE) ob++;
            cyc();
        end
        if (v.rst_bit >= 0) begin
            chk("rst_point_reached", rst_hit, 1);
            RSTN = 1'b1;
            cyc();
            chk_reset_outputs("mid_read_rst");
            RSTN = 1'b0;
            bus.B_UTIL = 1'b0;
            bus.S_READY = 1'b0;
            cyc();
            chk("post_rst_idle", bus.S_BSY, 0);
        end else begin
            chk("busy_wait_end", bus.S_BSY, 1);
            bus.B_UTIL = 1'b0;
            bus.B_BUS_IN = 1'b0;
            bus.S_READY = 1'b0;
            cyc();
            chk("busy_drop", bus.S_BSY, 0);
            chk("ack_pulses", ack_n - a0, v.acks);
            chk("wen_cycles", wen_n - w0, v.wens);
            chk("ren_cycles", ren_n - r0, v.rens);
            chk("oe_cycles", oe_n - o0, v.oes);
            if (v.oes == 8) chk("read_bits", rbits, v.rdata);
            if (v.wens > 0) begin
                chk("wen_addr", w_addr, v.addr[11:0]);
                chk("wen_data", w_dout, v.wdata);
            end
        end
    endtask

    vec_t tbl[6];

    initial begin
        int a0, w0, r0, o0;
        //          rw    addr      wdata  sdin   dly early rst  hit  ack wen ren oe rdata
        tbl[0] = '{1'b1, 16'h1234, 8'hAD, 8'h00, 0, 1'b1, -1, 1'b1, 2, 1, 0, 0, 8'h00};
        tbl[1] = '{1'b0, 16'h1234, 8'h00, 8'hB5, 3, 1'b0, -1, 1'b1, 2, 0, 4, 8, 8'hB5};
        tbl[2] = '{1'b1, 16'h2234, 8'h77, 8'h00, 0, 1'b1, -1, 1'b0, 0, 0, 0, 0, 8'h00};
        tbl[3] = '{1'b0, 16'h1ABC, 8'h00, 8'h5A, 0, 1'b1, -1, 1'b1, 2, 0, 1, 8, 8'h5A};
        tbl[4] = '{1'b1, 16'h1FFF, 8'h00, 8'h00, 2, 1'b0, -1, 1'b1, 2, 3, 0, 0, 8'h00};
        tbl[5] = '{1'b0, 16'h0234, 8'h00, 8'hFF, 0, 1'b1, -1, 1'b0, 0, 0, 0, 0, 8'h00};

        RSTN = 1'b1;
        bus.B_UTIL = 1'b0;
        bus.B_RW = 1'b0;
        bus.B_BUS_IN = 1'b0;
        bus.S_DIN = 8'h00;
        bus.S_READY = 1'b0;
        repeat (3) cyc();
        chk_reset_outputs("reset");
        RSTN = 1'b0;
        cyc();

        for (int i = 0; i < 6; i++) xact(tbl[i]);

        // Abort after 9 address bits, then a clean write.
        a0 = ack_n;
        w0 = wen_n;
        r0 = ren_n;
        o0 = oe_n;
        bus.B_UTIL = 1'b1;
        bus.B_RW = 1'b1;
        bus.B_BUS_IN = 1'b0;
        for (int i = 1; i < 9; i++) begin
            cyc();
            bus.B_BUS_IN = i[0];
        end
        cyc();
        chk("abort_busy", bus.S_BSY, 1);
        bus.B_UTIL = 1'b0;
        cyc();
        chk("abort_idle", bus.S_BSY, 0);
        cyc();
        chk("abort_acks", ack_n - a0, 0);
        chk("abort_wen", wen_n - w0, 0);
        chk("abort_ren", ren_n - r0, 0);
        chk("abort_oe", oe_n - o0, 0);
        xact('{1'b1, 16'h1001, 8'h3C, 8'h00, 0, 1'b1, -1, 1'b1,
               2, 1, 0, 0, 8'h00});

        // Reset while read bit 3 is on the bus.
        xact('{1'b0, 16'h1234, 8'h00, 8'hB5, 1, 1'b0, 3, 1'b1,
               2, 0, 2, 8, 8'hB5});

        // Back-to-back writes, one idle edge between them.
        xact('{1'b1, 16'h1055, 8'h11, 8'h00, 0, 1'b1, -1, 1'b1,
               2, 1, 0, 0, 8'h00});
        xact('{1'b1, 16'h1AAA, 8'hEE, 8'h00, 1, 1'b0, -1, 1'b1,
               2, 2, 0, 0, 8'h00});

        chk("protocol_violations", viol_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
